// File: rtl/spi_shift_engine.sv
// SPI shift engine: serialises a transmit character onto mosi and assembles
// the received character from miso, paced by SCLK edge strobes from an
// external clock generator. Character length is 1..MAX_CHAR bits, and either
// bit order is supported.
module spi_shift_engine #(
    parameter int MAX_CHAR = 32,
    parameter int LEN_W    = 5
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                go,
    input  logic                pos_edge,
    input  logic                neg_edge,
    input  logic [LEN_W-1:0]    len,
    input  logic                lsb,
    input  logic                tx_negedge,
    input  logic                rx_negedge,
    input  logic                wr_en,
    input  logic [MAX_CHAR-1:0] wr_data,
    input  logic                miso,
    output logic                tip,
    output logic                last,
    output logic                mosi,
    output logic [MAX_CHAR-1:0] rx_data,
    output logic                done
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t              r_state;
    logic [LEN_W:0]      r_cnt;      // one extra bit so MAX_CHAR fits
    logic [LEN_W:0]      r_len_q;
    logic                r_lsb_q;
    logic [MAX_CHAR-1:0] r_tx_q;

    logic                w_tx_edge;
    logic                w_rx_edge;
    logic [LEN_W:0]      w_len_eff;
    logic [LEN_W-1:0]    w_tx_idx;
    logic [LEN_W-1:0]    w_rx_idx;

    assign w_tx_edge = tx_negedge ? neg_edge : pos_edge;
    assign w_rx_edge = rx_negedge ? neg_edge : pos_edge;
    assign w_len_eff = (len == '0) ? (LEN_W+1)'(MAX_CHAR) : {1'b0, len};

    // Bit indices use the pre-decrement count; low LEN_W bits suffice because
    // every legal index is below MAX_CHAR and the arithmetic wraps correctly.
    assign w_tx_idx = r_lsb_q ? (r_len_q[LEN_W-1:0] - r_cnt[LEN_W-1:0])
                              : (r_cnt[LEN_W-1:0] - LEN_W'(1));
    assign w_rx_idx = r_lsb_q ? (r_len_q[LEN_W-1:0] - r_cnt[LEN_W-1:0] - LEN_W'(1))
                              : r_cnt[LEN_W-1:0];

    assign tip  = (r_state == XFER);
    assign last = tip && (r_cnt == '0);

    // Transfer FSM with shift/sample datapath; done is a registered pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_len_q <= '0;
            r_lsb_q <= 1'b0;
            r_tx_q  <= '0;
            mosi    <= 1'b0;
            rx_data <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A write in the go cycle is the data that gets sent.
                    if (wr_en) r_tx_q <= wr_data;
                    if (go) begin
                        r_state <= XFER;
                        r_len_q <= w_len_eff;
                        r_cnt   <= w_len_eff;
                        r_lsb_q <= lsb;
                    end
                end
                XFER: begin
                    if (w_tx_edge && (r_cnt != '0)) begin
                        mosi  <= r_tx_q[w_tx_idx];
                        r_cnt <= r_cnt - (LEN_W+1)'(1);
                    end
                    // Nothing to sample until the first bit has been driven.
                    if (w_rx_edge && (r_cnt < r_len_q)) rx_data[w_rx_idx] <= miso;
                    if (w_rx_edge && (r_cnt == '0)) begin
                        r_state <= IDLE;
                        done    <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: the bench plays the SCLK generator,
// queues the expected mosi bits at go and checks them as tx edges occur.
module tb_spi_shift_engine;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        go, pos_edge, neg_edge, lsb, tx_negedge, rx_negedge, wr_en;
    logic [4:0]  len;
    logic [31:0] wr_data;
    logic        miso;
    logic        tip, last, mosi, done;
    logic [31:0] rx_data;

    logic        loop_en;
    logic        miso_fix;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_txq;
    logic [31:0] m_rx;
    int          m_n;
    bit          q_mosi[$];

    always #5 clk_i = ~clk_i;

    assign miso = loop_en ? mosi : miso_fix;

    spi_shift_engine #(.MAX_CHAR(32), .LEN_W(5)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .go(go), .pos_edge(pos_edge),
        .neg_edge(neg_edge), .len(len), .lsb(lsb), .tx_negedge(tx_negedge),
        .rx_negedge(rx_negedge), .wr_en(wr_en), .wr_data(wr_data),
        .miso(miso), .tip(tip), .last(last), .mosi(mosi),
        .rx_data(rx_data), .done(done)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Issue go (optionally with a write) and queue the bits expected on mosi.
    task automatic start(input int l, input bit lsbv, input bit txn, input bit rxn,
                         input bit wr, input logic [31:0] d);
        len = l[4:0]; lsb = lsbv; tx_negedge = txn; rx_negedge = rxn;
        wr_en = wr; wr_data = d; go = 1'b1;
        if (wr) m_txq = d;
        m_n = (l == 0) ? 32 : l;
        q_mosi.delete();
        for (int i = 0; i < m_n; i++)
            q_mosi.push_back(lsbv ? m_txq[i] : m_txq[m_n-1-i]);
        tick();
        go = 1'b0; wr_en = 1'b0;
        chk("start_tip", tip, 1);
        chk("start_last", last, 0);
    endtask

    // Alternate SCLK strobes, tx edge first. inj_at injects go+write mid
    // transfer; stop_at returns early before that strobe index.
    task automatic run(input bit lp, input int inj_at, input int stop_at);
        bit          active;
        bit          neg, txf, rxf, fin;
        logic [31:0] mask;
        active  = 1'b1;
        loop_en = lp;
        for (int s = 0; s < 200 && active; s++) begin
            if (s == stop_at) return;
            neg = (s % 2 == 0) ? tx_negedge : !tx_negedge;
            txf = (neg == tx_negedge);
            rxf = (neg == rx_negedge);
            fin = rxf && (q_mosi.size() == 0);
            pos_edge = !neg; neg_edge = neg;
            tick();
            pos_edge = 1'b0; neg_edge = 1'b0;
            if (txf && q_mosi.size() > 0) chk("mosi", mosi, q_mosi.pop_front());
            if (fin) active = 1'b0;
            chk("done", done, fin);
            chk("tip", tip, active);
            chk("last", last, active && (q_mosi.size() == 0));
            if (s == inj_at) begin go = 1'b1; wr_en = 1'b1; wr_data = 32'h55; end
            tick();
            go = 1'b0; wr_en = 1'b0;
            chk("gap_done", done, 0);
            chk("gap_tip", tip, active);
        end
        if (active) begin
            tests++; fails++;
            $display("FAIL timeout: transfer still active, expected done");
        end
        mask = (m_n == 32) ? 32'hFFFF_FFFF : ((32'h1 << m_n) - 32'h1);
        m_rx = (m_rx & ~mask) | ((lp ? m_txq : 32'hFFFF_FFFF) & mask);
        chk("rx_data", rx_data, m_rx);
    endtask

    initial begin
        rst_ni = 1'b0; go = 0; pos_edge = 0; neg_edge = 0; lsb = 0;
        tx_negedge = 0; rx_negedge = 0; wr_en = 0; len = 0; wr_data = 0;
        loop_en = 1'b1; miso_fix = 1'b0; m_txq = 0; m_rx = 0; m_n = 0;
        #12;
        chk("rst_tip", tip, 0);
        chk("rst_last", last, 0);
        chk("rst_done", done, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_rx", rx_data, 0);
        rst_ni = 1'b1;
        tick();

        // 8-bit MSB first, tx on neg, rx on pos, loopback of 0xA5
        start(8, 0, 1, 0, 1, 32'hA5);
        run(1, -1, -1);

        // 32-bit LSB first
        start(0, 1, 1, 0, 1, 32'h8000_0001);
        run(1, -1, -1);

        // preset rx_data to FFFF0000, then 4 bits with miso tied high
        start(0, 0, 1, 0, 1, 32'hFFFF_0000);
        run(1, -1, -1);
        miso_fix = 1'b1;
        start(4, 0, 1, 0, 0, 32'h0);
        run(0, -1, -1);

        // coinciding tx/rx edges on neg, 2 bits
        start(2, 0, 1, 1, 1, 32'h2);
        run(1, -1, -1);

        // go + write mid transfer is ignored; next transfer sends old data
        start(8, 0, 1, 0, 1, 32'h3C);
        run(1, 3, -1);
        start(8, 0, 1, 0, 0, 32'h0);
        run(1, -1, -1);

        // reset after 3 bits of an 8-bit transfer
        start(8, 0, 1, 0, 1, 32'hA5);
        run(1, -1, 6);
        rst_ni = 1'b0;
        #1;
        chk("abort_tip", tip, 0);
        chk("abort_last", last, 0);
        chk("abort_done", done, 0);
        chk("abort_mosi", mosi, 0);
        chk("abort_rx", rx_data, 0);
        m_txq = 0; m_rx = 0;
        tick();
        chk("abort_done2", done, 0);
        rst_ni = 1'b1;
        start(8, 0, 1, 0, 1, 32'h5A);
        run(1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_shift_engine.md
SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 SHALL have parameter MAX_CHAR, default 32, maximum character length in bits.
REQ-002 SHALL have parameter LEN_W, default 5, width of the len port; 2^LEN_W == MAX_CHAR.
REQ-003 SHALL have port clk_i, input, 1, system clock; one clock, all state on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port go, input, 1, start-transfer pulse.
REQ-006 SHALL have port pos_edge, input, 1, SCLK rising-edge strobe from the clock generator.
REQ-007 SHALL have port neg_edge, input, 1, SCLK falling-edge strobe from the clock generator.
REQ-008 SHALL have port len, input, LEN_W, character length in bits; 0 means MAX_CHAR.
REQ-009 SHALL have port lsb, input, 1; 1 means LSB first, 0 means MSB first.
REQ-010 SHALL have port tx_negedge, input, 1; 1 means drive mosi on neg_edge, else on pos_edge.
REQ-011 SHALL have port rx_negedge, input, 1; 1 means sample miso on neg_edge, else on pos_edge.
REQ-012 SHALL have port wr_en, input, 1, transmit-data write strobe.
REQ-013 SHALL have port wr_data, input, MAX_CHAR, transmit data.
REQ-014 SHALL have port miso, input, 1, serial receive data, already synchronous to clk_i.
REQ-015 SHALL have port tip, output, 1, transfer in progress; drives the clock generator enable.
REQ-016 SHALL have port last, output, 1, final-bit indicator; drives the clock generator last_clk.
REQ-017 SHALL have port mosi, output, 1, serial transmit data.
REQ-018 SHALL have port rx_data, output, MAX_CHAR, received data.
REQ-019 SHALL have port done, output, 1, one-cycle transfer-complete pulse.

Function
REQ-020 SHALL define tx_edge = tx_negedge ? neg_edge : pos_edge, and rx_edge = rx_negedge ? neg_edge : pos_edge.
REQ-021 SHALL implement two states, IDLE (tip=0) and XFER (tip=1).
REQ-022 SHALL, on go in IDLE, enter XFER next cycle, latch len_q = (len==0 ? MAX_CHAR : len) and lsb_q, and load bit counter cnt = len_q.
REQ-023 SHALL ignore go while in XFER, with no restart and no state change.
REQ-024 SHALL load wr_data into internal tx_q on wr_en only while tip=0, including the go cycle, so a same-cycle write is the data transmitted.
REQ-025 SHALL drop wr_en while tip=1 silently, leaving tx_q unchanged.
REQ-026 SHALL, on tx_edge in XFER with cnt!=0, set mosi = tx_q[cnt-1] (MSB first) or tx_q[len_q-cnt] (LSB first), and decrement cnt by 1.
REQ-027 SHALL, on rx_edge in XFER with cnt<len_q (sampled before the same-cycle decrement), write miso to rx_data[cnt] (MSB first) or rx_data[len_q-cnt-1] (LSB first).
REQ-028 SHALL hold rx_data bits at index >= len_q unchanged.
REQ-029 SHALL drive last combinationally as tip && (cnt==0).
REQ-030 SHALL, on rx_edge in XFER with cnt==0, sample the final bit, return to IDLE next cycle, and pulse done high for exactly that one cycle.
REQ-031 SHALL, when tx_edge and rx_edge coincide (tx_negedge==rx_negedge), evaluate both rules in REQ-026/REQ-027 against the pre-update cnt.
REQ-032 SHALL hold mosi at its last driven value in IDLE.
REQ-033 SHALL hold rx_data stable from done until the next transfer's first sample.
REQ-034 SHALL treat pos_edge and neg_edge asserted in the same cycle as illegal, with behaviour undefined.
REQ-035 SHALL take no action on edges received in IDLE.
REQ-036 SHALL size cnt as LEN_W+1 bits so that the value MAX_CHAR is representable.

Reset
REQ-037 SHALL, while rst_ni=0, immediately force state=IDLE, tip=0, last=0, done=0, mosi=0, cnt=0, len_q=0, lsb_q=0, tx_q=0, and rx_data=0.
REQ-038 SHALL, on reset asserted mid-transfer, abort the transfer with no done pulse, and accept go on the first cycle after release.

Verification
REQ-039 SHALL verify: len=8, lsb=0, tx_negedge=1, rx_negedge=0, wr_data=0xA5, miso looped from mosi -> mosi sequence 1,0,1,0,0,1,0,1; rx_data[7:0]=0xA5; exactly one done; tip low afterwards.
REQ-040 SHALL verify: len=0 (32 bits), lsb=1, wr_data=0x8000_0001, loopback -> first mosi bit 1; rx_data=0x8000_0001 after 32 rx_edges.
REQ-041 SHALL verify: len=4, miso tied 1, rx_data preset to 0xFFFF_0000 -> rx_data=0xFFFF_000F; bits 31:4 untouched.
REQ-042 SHALL verify: tx_negedge=rx_negedge=1, len=2, wr_data=0x2, loopback -> rx_data[1:0]=2'b10; last high only while cnt==0.
REQ-043 SHALL verify: go plus wr_en=0x55 mid-transfer -> no restart; tx_q retains the old value; the next transfer sends the old data.
REQ-044 SHALL verify: rst_ni pulsed low after 3 bits of an 8-bit transfer -> all outputs 0 immediately; no done; a new go is accepted on the cycle after release.
